ram_bytewise: RTL and testbench

Parametrised single-port synchronous RAM, the successor to the team's fixed 32x32 word RAM. It adds configurable width and depth, per-byte write enables, and separate input/output data ports with a read-valid strobe. After every reset, a hardware clear sequencer zeroes the entire array before any access is accepted. It sits between the CPU datapath and the load/store unit as data memory, or serves as a generic scratch buffer.

---
 rtl/ram_bytewise.sv | 133 +++++++++++++
 tb/tb_ram_bytewise.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bytewise.sv
// Byte-enabled single-port RAM with a hardware clear sequencer after reset.
// Define RAM_OUTREG_EN to add a second output register (2-cycle read latency).
`timescale 1ns/1ps
module ram_bytewise #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    wena,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    rvalid,
  output logic                    busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    rd_d;
  logic                    wr_d;
  logic [DATA_WIDTH-1:0]   rdata_d;

  // Requests only count once the clear sequence has finished.
  always_comb begin
    rd_d    = (state_q == READY) && ena && !wena;
    wr_d    = (state_q == READY) && ena && wena;
    rdata_d = mem_q[addr];
  end

  // Clear sequencer: walk every address once, then open for access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  // Array port: zero fill while clearing, byte-merged writes when ready.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_d) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

`ifdef RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] dout1_q;
  logic                  rv1_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rvalid_q;

  // First read stage captures the array word and holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout1_q <= '0;
      rv1_q   <= 1'b0;
    end else begin
      rv1_q <= rd_d;
      if (rd_d) begin
        dout1_q <= rdata_d;
      end
    end
  end

  // Second stage retimes data and strobe together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout1_q;
      rvalid_q <= rv1_q;
    end
  end
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rvalid_q;

  // Single read register; holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_d;
      if (rd_d) begin
        dout_q <= rdata_d;
      end
    end
  end
`endif

  assign dout   = dout_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_ram_bytewise.sv
// Scoreboard bench for ram_bytewise: default 32x32 instance plus a 16-bit x 8 instance.
// Expected read data comes from a behavioural array model updated at issue time.
`timescale 1ns/1ps
module tb_ram_bytewise;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ena, wena, rvalid, busy;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] din, dout;

  logic        rst_nb, enab, wenab, rvalidb, busyb;
  logic [1:0]  beb;
  logic [2:0]  addrb;
  logic [15:0] dinb, doutb;

  ram_bytewise dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wena(wena), .be(be),
    .addr(addr), .din(din), .dout(dout), .rvalid(rvalid), .busy(busy)
  );

  ram_bytewise #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dutb (
    .clk(clk), .rst_n(rst_nb), .ena(enab), .wena(wenab), .be(beb),
    .addr(addrb), .din(dinb), .dout(doutb), .rvalid(rvalidb), .busy(busyb)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] model [32];
  logic [31:0] q [$];
  logic [15:0] modelb [8];
  logic [15:0] qb [$];
  int          streak = 0;
  int          max_streak = 0;
  int          rv_busy = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor A: pop expected word whenever the DUT strobes rvalid.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk); #1;
      if (rvalid) begin
        streak++;
        if (streak > max_streak) max_streak = streak;
        if (busy) rv_busy++;
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL rd_unexpected actual=%h expected=none", dout);
        end else begin
          e = q.pop_front();
          chk("rd_data", dout, e);
          last_rd = e;
        end
      end else begin
        streak = 0;
      end
    end
  end

  // Monitor B: same scheme for the narrow instance.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk); #1;
      if (rvalidb) begin
        if (qb.size() == 0) begin
          checks++; fails++;
          $display("FAIL b_rd_unexpected actual=%h expected=none", doutb);
        end else begin
          e = qb.pop_front();
          chk("b_rd_data", {16'h0, doutb}, {16'h0, e});
        end
      end
    end
  end

  task automatic wr(int a, logic [31:0] d, logic [3:0] b);
    @(negedge clk);
    ena = 1'b1; wena = 1'b1; addr = a[4:0]; din = d; be = b;
    for (int i = 0; i < 4; i++)
      if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic rd(int a);
    @(negedge clk);
    ena = 1'b1; wena = 1'b0; addr = a[4:0];
    be = 4'($urandom); din = $urandom;
    q.push_back(model[a]);
  endtask

  task automatic idle();
    @(negedge clk);
    ena = 1'b0; wena = 1'($urandom); addr = 5'($urandom);
    din = $urandom; be = 4'($urandom);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk(name, q.size(), 0);
  endtask

  // Reset, optionally inject a write or a second reset, count busy edges.
  task automatic clear_run(string name, int lock_at, int pulse_at);
    int n = 0;
    bit pulsed = 0;
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; #1;
    chk("rst_busy", busy, 1);
    chk("rst_dout", dout, 0);
    chk("rst_rvalid", rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
      if (n == lock_at) begin
        ena = 1'b1; wena = 1'b1; addr = 5'd3; din = 32'hDEADBEEF; be = 4'hF;
      end else begin
        ena = 1'b0;
      end
      if (n == pulse_at && !pulsed) begin
        pulsed = 1;
        @(negedge clk); rst_n = 1'b0; #1;
        chk("midrst_busy", busy, 1);
        chk("midrst_dout", dout, 0);
        @(negedge clk); rst_n = 1'b1;
        n = 0;
      end
    end
    ena = 1'b0;
    chk(name, n, 32);
    for (int i = 0; i < 32; i++) model[i] = '0;
    last_rd = '0;
  endtask

  task automatic wrb(int a, logic [15:0] d, logic [1:0] b);
    @(negedge clk);
    enab = 1'b1; wenab = 1'b1; addrb = 3'(a); dinb = d; beb = b;
    for (int i = 0; i < 2; i++)
      if (b[i]) modelb[a % 8][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic rdb(int a);
    @(negedge clk);
    enab = 1'b1; wenab = 1'b0; addrb = 3'(a); beb = 2'b11;
    qb.push_back(modelb[a % 8]);
  endtask

  task automatic idleb();
    @(negedge clk);
    enab = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst_n = 1'b0; ena = 1'b0; wena = 1'b0; be = '0; addr = '0; din = '0;
    rst_nb = 1'b0; enab = 1'b0; wenab = 1'b0; beb = '0; addrb = '0; dinb = '0;
    for (int i = 0; i < 8; i++) modelb[i] = '0;
    repeat (3) @(negedge clk);

    clear_run("clear_cycles", 10, -1);
    rd(0); rd(17); rd(31); rd(3);
    idle(); drain("drain_zero");
    repeat (3) idle();
    chk("hold_dout", dout, last_rd);
    chk("idle_rvalid", rvalid, 0);

    wr(5, 32'hAABBCCDD, 4'b1111);
    wr(5, 32'h11223344, 4'b0101);
    rd(5);
    idle(); drain("drain_byte");
    chk("byte_merge", dout, 32'hAA22CC44);

    for (int k = 0; k < 32; k++) wr(k, 32'(k) * 32'h01010101, 4'hF);
    idle();
    max_streak = 0;
    for (int k = 0; k < 32; k++) rd(k);
    idle(); drain("drain_b2b");
    chk("b2b_streak", max_streak, 32);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: idle();
        1: wr($urandom_range(0, 31), $urandom, 4'($urandom));
        default: rd($urandom_range(0, 31));
      endcase
    end
    idle(); drain("drain_rand");
    repeat (2) idle();
    chk("hold_dout_rand", dout, last_rd);

    clear_run("midclear_cycles", -1, 20);
    for (int k = 0; k < 32; k++) rd(k);
    idle(); drain("drain_midclear");
    chk("rv_while_busy", rv_busy, 0);

    @(negedge clk);
    rst_nb = 1'b1;
    nb = 0;
    while (nb < 50) begin
      @(posedge clk); #1;
      nb++;
      if (!busyb) break;
    end
    chk("b_clear_cycles", nb, 8);
    wrb(7, 16'hBEEF, 2'b10);
    rdb(7);
    idleb();
    repeat (4) @(negedge clk);
    chk("b_byte_hi", {16'h0, doutb}, 32'h0000BE00);
    wrb(7 + 1, 16'h1234, 2'b11);
    rdb(0);
    rdb(7);
    idleb();
    for (int i = 0; i < 10 && qb.size() > 0; i++) @(negedge clk);
    chk("b_drain", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
